hcube_route_unit: RTL and testbench

- Parametrised route-computation stage for hypercube NoC routers.
- Takes a destination address, XORs it with the node's own address, and decides either local core delivery or the next dimension to traverse.
- Generalises the fixed 4-bit lowest-set-bit selector to DIM dimensions with three selection modes, including congestion-aware adaptive routing.
- Uses valid/ready handshakes with a registered, one-entry output slice. Sits between the router input buffer and the crossbar arbiter.

---
 rtl/hcube_pkg.sv | 27 ++
 rtl/hcube_prio_pick.sv | 34 +++
 rtl/hcube_route_unit.sv | 98 +++++++++
 tb/tb_hcube_route_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hcube_pkg.sv
// Shared types and helpers for the hypercube router datapath.
package hcube_pkg;

  // Dimension selection policy for the route unit.
  typedef enum logic [1:0] {
    RM_LOWEST   = 2'd0,
    RM_HIGHEST  = 2'd1,
    RM_ADAPTIVE = 2'd2
  } route_mode_e;

  // Largest supported hypercube and the matching index width.
  localparam int MAX_DIM = 16;
  localparam int MAX_DW  = 4;

  // Route decision as handed to the crossbar arbiter.
  typedef struct packed {
    logic              core;
    logic [MAX_DW-1:0] dim;
    logic [MAX_DIM-1:0] rem;
  } route_dec_t;

  // Width of a dimension index; never narrower than one bit.
  function automatic int dim_w(input int d);
    return (d < 2) ? 1 : $clog2(d);
  endfunction

endpackage

// File: rtl/hcube_prio_pick.sv
// Rotating priority encoder: finds the first set bit of req scanning
// upward from index start and wrapping at W-1 back to 0.
module hcube_prio_pick #(
  parameter int W  = 4,
  parameter int SW = 2
) (
  input  logic [W-1:0]  req,
  input  logic [SW-1:0] start,
  output logic [SW-1:0] idx,
  output logic          found
);

  logic [W-1:0] rot;
  logic [SW-1:0] off;
  logic [SW:0]   sum;

  // Rotate so that bit i of rot corresponds to request index start+i.
  assign rot   = W'({req, req} >> start);
  assign found = |rot;

  // Lowest set bit of the rotated vector is the offset from start.
  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    off = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (rot[i]) off = SW'(i);
    end
  end

  // Undo the rotation: start + offset, wrapped modulo W.
  assign sum = {1'b0, start} + {1'b0, off};
  assign idx = (sum >= (SW+1)'(W)) ? SW'(sum - (SW+1)'(W)) : sum[SW-1:0];

endmodule

// File: rtl/hcube_route_unit.sv
// Hypercube route-computation stage: XORs the destination with this
// node's address and picks local delivery or the next dimension to
// traverse, behind a one-entry registered valid/ready output slice.
module hcube_route_unit
  import hcube_pkg::*;
#(
  parameter int             DIM       = 4,
  parameter logic [DIM-1:0] NODE_ADDR = '0,
  parameter int             MODE      = 0,
  parameter int             DW        = dim_w(DIM)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DIM-1:0] in_dest,
  input  logic [DIM-1:0] port_busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_core,
  output logic [DW-1:0]  out_dim,
  output logic [DIM-1:0] out_rem
);

  localparam bit HIGHEST  = (MODE == int'(RM_HIGHEST));
  localparam bit ADAPTIVE = (MODE == int'(RM_ADAPTIVE));

  logic           accept;
  logic [DIM-1:0] diff, diff_rev, cand_free, cand, fwd_req;
  logic [DW-1:0]  rr_ptr, fwd_start, fwd_idx, rev_idx, hi_dim, pick_dim, ptr_next;
  logic           fwd_found, rev_found, pick_found;
  logic           core_next;
  logic [DW-1:0]  dim_next;
  logic [DIM-1:0] rem_next;

  // The slot frees up in the same cycle the consumer drains it.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign diff = in_dest ^ NODE_ADDR;

  // Prefer uncongested dimensions, but fall back to any differing one
  // so a fully busy mask never stalls the packet here.
  assign cand_free = diff & ~port_busy;
  assign cand      = (cand_free != '0) ? cand_free : diff;
  assign fwd_req   = ADAPTIVE ? cand : diff;
  assign fwd_start = ADAPTIVE ? rr_ptr : '0;

  // Bit-reverse the difference so a lowest-first search finds the highest bit.
  always_comb begin
    for (int i = 0; i < DIM; i++) diff_rev[i] = diff[DIM-1-i];
  end

  hcube_prio_pick #(.W(DIM), .SW(DW)) u_pick_fwd (
    .req   (fwd_req),
    .start (fwd_start),
    .idx   (fwd_idx),
    .found (fwd_found)
  );

  hcube_prio_pick #(.W(DIM), .SW(DW)) u_pick_rev (
    .req   (diff_rev),
    .start ('0),
    .idx   (rev_idx),
    .found (rev_found)
  );

  assign hi_dim     = DW'(DIM - 1) - rev_idx;
  assign pick_dim   = HIGHEST ? hi_dim : fwd_idx;
  assign pick_found = HIGHEST ? rev_found : fwd_found;

  // No differing bit means the packet has arrived.
  assign core_next = !pick_found;
  assign dim_next  = core_next ? '0 : pick_dim;
  assign rem_next  = core_next ? '0 : (diff & ~(DIM'(1) << pick_dim));
  assign ptr_next  = (pick_dim == DW'(DIM - 1)) ? '0 : pick_dim + DW'(1);

  // Output slice and adaptive pointer: load on accept, drop valid on drain.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_core  <= 1'b0;
      out_dim   <= '0;
      out_rem   <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_core  <= core_next;
      out_dim   <= dim_next;
      out_rem   <= rem_next;
      if (ADAPTIVE && !core_next) rr_ptr <= ptr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hcube_route_unit.sv
// Bench for hcube_route_unit: three instances (lowest, highest, adaptive)
// driven in lockstep, checked against a scoreboard plus directed values.
module tb_hcube_route_unit;

  typedef struct packed {
    logic       core;
    logic [1:0] dim;
    logic [3:0] rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready;
  logic [3:0] in_dest, port_busy;
  logic       ir [3];
  logic       ov [3];
  logic       oc [3];
  logic [1:0] od [3];
  logic [3:0] orem [3];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ptr   = 0;
  int   n_out [3] = '{0, 0, 0};
  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  hcube_route_unit #(.DIM(4), .NODE_ADDR(4'b0101), .MODE(0)) u_lo (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .in_dest(in_dest), .port_busy(port_busy), .out_valid(ov[0]),
    .out_ready(out_ready), .out_core(oc[0]), .out_dim(od[0]), .out_rem(orem[0]));

  hcube_route_unit #(.DIM(4), .NODE_ADDR(4'b0101), .MODE(1)) u_hi (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .in_dest(in_dest), .port_busy(port_busy), .out_valid(ov[1]),
    .out_ready(out_ready), .out_core(oc[1]), .out_dim(od[1]), .out_rem(orem[1]));

  hcube_route_unit #(.DIM(4), .NODE_ADDR(4'b0000), .MODE(2)) u_ad (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .in_dest(in_dest), .port_busy(port_busy), .out_valid(ov[2]),
    .out_ready(out_ready), .out_core(oc[2]), .out_dim(od[2]), .out_rem(orem[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decision: straightforward bit scans over the difference.
  function automatic exp_t model(input int mode, input logic [3:0] node,
                                 input logic [3:0] dest, input logic [3:0] busy,
                                 input int ptr);
    logic [3:0] diff, cand;
    exp_t       e;
    int         k;
    diff = dest ^ node;
    e    = '0;
    if (diff == 4'b0000) begin
      e.core = 1'b1;
      return e;
    end
    cand = diff;
    if (mode == 2 && (diff & ~busy) != 4'b0000) cand = diff & ~busy;
    for (int n = 0; n < 4; n++) begin
      case (mode)
        0:       k = n;
        1:       k = 3 - n;
        default: k = (ptr + n) % 4;
      endcase
      if (cand[k[1:0]]) begin
        e.dim          = k[1:0];
        e.rem          = diff;
        e.rem[k[1:0]]  = 1'b0;
        return e;
      end
    end
    return e;
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t q_front(input int d);
    case (d)
      0:       return q0[0];
      1:       return q1[0];
      default: return q2[0];
    endcase
  endfunction

  // Compare an instance's current outputs with the oldest pending expectation.
  task automatic check_front(input int d, input string tag);
    exp_t e;
    if (q_size(d) == 0) begin
      check($sformatf("%s%0d_unexpected", tag, d), 32'(ov[d]), 32'(1'b0));
    end else begin
      e = q_front(d);
      check($sformatf("%s%0d_valid", tag, d), 32'(ov[d]),   32'(1'b1));
      check($sformatf("%s%0d_core",  tag, d), 32'(oc[d]),   32'(e.core));
      check($sformatf("%s%0d_dim",   tag, d), 32'(od[d]),   32'(e.dim));
      check($sformatf("%s%0d_rem",   tag, d), 32'(orem[d]), 32'(e.rem));
    end
  endtask

  // Scoreboard: retire outputs taken at the next edge, then record accepts.
  always @(negedge clk) begin
    exp_t e2, dummy;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      q2.delete();
      m_ptr = 0;
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && out_ready) begin
          check_front(d, "sb");
          n_out[d]++;
          case (d)
            0:       if (q0.size() > 0) dummy = q0.pop_front();
            1:       if (q1.size() > 0) dummy = q1.pop_front();
            default: if (q2.size() > 0) dummy = q2.pop_front();
          endcase
        end
      end
      if (in_valid && ir[0]) begin
        q0.push_back(model(0, 4'b0101, in_dest, port_busy, 0));
        q1.push_back(model(1, 4'b0101, in_dest, port_busy, 0));
        e2 = model(2, 4'b0000, in_dest, port_busy, m_ptr);
        q2.push_back(e2);
        if (!e2.core) m_ptr = (int'(e2.dim) + 1) % 4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] dest, input logic [3:0] busy);
    in_valid  = 1'b1;
    in_dest   = dest;
    port_busy = busy;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_dest  = 'x;
    step();
  endtask

  initial begin
    int base [3];
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_dest   = 'x;
    port_busy = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst_valid%0d", d), 32'(ov[d]),   0);
      check($sformatf("rst_core%0d",  d), 32'(oc[d]),   0);
      check($sformatf("rst_dim%0d",   d), 32'(od[d]),   0);
      check($sformatf("rst_rem%0d",   d), 32'(orem[d]), 0);
      check($sformatf("rst_ready%0d", d), 32'(ir[d]),   1);
    end
    #5 rst_n = 1'b1;

    // Adaptive: busy mask skips dim 0, then all-busy fallback.
    drive(4'b1111, 4'b0001);
    check("ad_dim_a",   32'(od[2]),   32'd1);
    check("ad_rem_a",   32'(orem[2]), 32'b1101);
    drive(4'b1111, 4'b1111);
    check("ad_dim_b",   32'(od[2]),   32'd2);
    check("ad_rem_b",   32'(orem[2]), 32'b1011);

    // Local delivery and a multi-hop difference in lowest/highest modes.
    drive(4'b0101, 4'b0000);
    check("lo_core",    32'(oc[0]),   32'd1);
    check("lo_core_d",  32'(od[0]),   32'd0);
    check("lo_core_r",  32'(orem[0]), 32'd0);
    check("hi_core",    32'(oc[1]),   32'd1);
    drive(4'b1011, 4'b0000);
    check("lo_hop_c",   32'(oc[0]),   32'd0);
    check("lo_hop_d",   32'(od[0]),   32'd1);
    check("lo_hop_r",   32'(orem[0]), 32'b1100);
    check("hi_hop_d",   32'(od[1]),   32'd3);
    check("hi_hop_r",   32'(orem[1]), 32'b0110);
    idle();
    idle();

    // Backpressure: held decision stays put while a new request waits.
    out_ready = 1'b0;
    drive(4'b0110, 4'b0000);
    in_dest = 4'b0011;
    for (int c = 0; c < 3; c++) begin
      port_busy = 4'($urandom);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("bp_ready%0d", d), 32'(ir[d]), 0);
        check_front(d, "bp_hold");
      end
      step();
    end
    // Handoff and new accept on the same edge.
    out_ready = 1'b1;
    step();
    for (int d = 0; d < 3; d++) check_front(d, "bp_next");
    idle();
    idle();

    // Streaming: one accept and one decision per cycle.
    for (int d = 0; d < 3; d++) base[d] = n_out[d];
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      in_dest   = 4'($urandom);
      port_busy = 4'($urandom);
      for (int d = 0; d < 3; d++) begin
        check($sformatf("st_ready%0d", d), 32'(ir[d]), 1);
        if (i > 0) check($sformatf("st_valid%0d", d), 32'(ov[d]), 1);
      end
      step();
    end
    idle();
    idle();
    for (int d = 0; d < 3; d++)
      check($sformatf("st_count%0d", d), 32'(n_out[d] - base[d]), 32'd8);

    // Reset while a decision is held under backpressure.
    out_ready = 1'b0;
    drive(4'b1000, 4'b0000);
    in_valid = 1'b0;
    for (int d = 0; d < 3; d++) check($sformatf("mr_held%0d", d), 32'(ov[d]), 1);
    #3 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("mr_valid%0d", d), 32'(ov[d]),   0);
      check($sformatf("mr_rem%0d",   d), 32'(orem[d]), 0);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int d = 0; d < 3; d++) check($sformatf("mr_ready%0d", d), 32'(ir[d]), 1);
    out_ready = 1'b1;
    drive(4'b1111, 4'b0000);
    check("mr_ptr_dim", 32'(od[2]),   32'd0);
    check("mr_ptr_rem", 32'(orem[2]), 32'b1110);
    idle();
    idle();

    for (int d = 0; d < 3; d++) check($sformatf("drained%0d", d), 32'(q_size(d)), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
